// File: rtl/l2_tlb_ctrl.sv
// Sequencing controller for the shared 4-way L2 TLB: it arbitrates ITLB/DTLB misses,
// walks the page table on a miss, refills a victim way and replays the lookup.
module l2_tlb_ctrl #(
  parameter int VPN_W = 20,
  parameter int IDX_W = 4
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic [1:0]             req_valid_i,
  input  logic [VPN_W-1:0]       req_vpn0_i,
  input  logic [VPN_W-1:0]       req_vpn1_i,
  output logic [1:0]             req_ready_o,
  output logic [1:0]             resp_valid_o,
  output logic                   resp_fault_o,
  output logic                   arr_rd_en_o,
  output logic [IDX_W-1:0]       arr_idx_o,
  output logic [VPN_W-IDX_W-1:0] arr_tag_o,
  input  logic [3:0]             hits_i,
  input  logic [3:0]             valid_i,
  output logic                   ptw_req_valid_o,
  input  logic                   ptw_req_ready_i,
  output logic [VPN_W-1:0]       ptw_req_vpn_o,
  input  logic                   ptw_resp_valid_i,
  input  logic                   ptw_resp_err_i,
  output logic                   refill_en_o,
  output logic [3:0]             refill_way_o,
  input  logic                   flush_i,
  output logic                   flush_all_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_COMPARE, S_PTW_REQ, S_PTW_WAIT, S_REFILL, S_RESP
  } state_e;

  state_e           state_q, state_d;
  logic             owner_q, owner_d;
  logic             last_grant_q, last_grant_d;
  logic [VPN_W-1:0] vpn_q, vpn_d;
  logic [1:0]       victim_q, victim_d;
  logic             victim_ptr_q, victim_ptr_d;
  logic [1:0]       repl_ptr_q, repl_ptr_d;
  logic             fault_q, fault_d;
  logic             flush_pend_q, flush_pend_d;

  logic [1:0]       grant;
  logic             flush_svc;
  logic [1:0]       free_way;
  logic             any_free;

  // last_grant_q holds the index of the previous winner (0 = ITLB, 1 = DTLB).
  always_comb begin
    grant = 2'b00;
    if (state_q == S_IDLE && !flush_pend_q) begin
      if (req_valid_i == 2'b11) grant = last_grant_q ? 2'b01 : 2'b10;
      else                      grant = req_valid_i;
    end
  end

  assign flush_svc = (state_q == S_IDLE) && flush_pend_q;

  always_comb begin
    free_way = 2'd0;
    any_free = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if (!valid_i[i]) begin
        free_way = 2'(i);
        any_free = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      vpn_q        <= '0;
      victim_q     <= 2'd0;
      victim_ptr_q <= 1'b0;
      repl_ptr_q   <= 2'd0;
      fault_q      <= 1'b0;
      flush_pend_q <= 1'b0;
    end else begin
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      vpn_q        <= vpn_d;
      victim_q     <= victim_d;
      victim_ptr_q <= victim_ptr_d;
      repl_ptr_q   <= repl_ptr_d;
      fault_q      <= fault_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    vpn_d        = vpn_q;
    victim_d     = victim_q;
    victim_ptr_d = victim_ptr_q;
    repl_ptr_d   = repl_ptr_q;
    fault_d      = fault_q;
    flush_pend_d = (flush_pend_q && !flush_svc) || flush_i;
    unique case (state_q)
      S_IDLE: begin
        if (grant != 2'b00) begin
          owner_d      = grant[1];
          last_grant_d = grant[1];
          vpn_d        = grant[1] ? req_vpn1_i : req_vpn0_i;
          state_d      = S_LOOKUP;
        end
      end
      S_LOOKUP: state_d = S_COMPARE;
      S_COMPARE: begin
        if (|hits_i) begin
          fault_d = 1'b0;
          state_d = S_RESP;
        end else begin
          victim_d     = any_free ? free_way : repl_ptr_q;
          victim_ptr_d = !any_free;
          state_d      = S_PTW_REQ;
        end
      end
      S_PTW_REQ: if (ptw_req_ready_i) state_d = S_PTW_WAIT;
      S_PTW_WAIT: begin
        if (ptw_resp_valid_i) begin
          if (ptw_resp_err_i) begin
            fault_d = 1'b1;
            state_d = S_RESP;
          end else begin
            state_d = S_REFILL;
          end
        end
      end
      S_REFILL: begin
        if (victim_ptr_q) repl_ptr_d = repl_ptr_q + 2'd1;
        state_d = S_LOOKUP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready_o     = 2'b00;
    resp_valid_o    = 2'b00;
    resp_fault_o    = 1'b0;
    arr_rd_en_o     = 1'b0;
    arr_idx_o       = '0;
    arr_tag_o       = '0;
    ptw_req_valid_o = 1'b0;
    ptw_req_vpn_o   = '0;
    refill_en_o     = 1'b0;
    refill_way_o    = 4'b0000;
    flush_all_o     = 1'b0;
    if (state_q != S_IDLE) begin
      arr_idx_o = vpn_q[IDX_W-1:0];
      arr_tag_o = vpn_q[VPN_W-1:IDX_W];
    end
    unique case (state_q)
      S_IDLE: begin
        req_ready_o = grant;
        flush_all_o = flush_svc;
      end
      S_LOOKUP: arr_rd_en_o = 1'b1;
      S_PTW_REQ: begin
        ptw_req_valid_o = 1'b1;
        ptw_req_vpn_o   = vpn_q;
      end
      S_REFILL: begin
        refill_en_o  = 1'b1;
        refill_way_o = 4'b0001 << victim_q;
      end
      S_RESP: begin
        resp_valid_o = owner_q ? 2'b10 : 2'b01;
        resp_fault_o = fault_q;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/l2_tlb_ctrl.md
Name: l2_tlb_ctrl

Overview:
- Sequencing controller for the 4-way shared L2 TLB. Arbitrates ITLB and DTLB miss requests round-robin, drives the set index and tag for the array read, and consumes the per-way hit and valid vectors.
- On a miss it issues a page-table-walk (PTW) request and chooses a victim way. It pulses the refill write and replays the lookup, so every successful translation completes as a hit.
- Sits between the L1 TLBs, the L2 TLB arrays/hit-merge datapath and the PTW.

Parameters:
- VPN_W, 20, virtual page number width.
- IDX_W, 4, set index width; index = vpn[IDX_W-1:0], tag = vpn[VPN_W-1:IDX_W].

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  2  request valid; bit0 = ITLB, bit1 = DTLB.
- req_vpn0  in  VPN_W  ITLB request VPN.
- req_vpn1  in  VPN_W  DTLB request VPN.
- req_ready  out  2  one-hot grant; the handshake completes when valid&ready.
- resp_valid  out  2  one-cycle response pulse to the owning requester.
- resp_fault  out  1  qualifies resp_valid; 1 = PTW reported an error.
- arr_rd_en  out  1  array read strobe.
- arr_idx  out  IDX_W  set index for read and refill.
- arr_tag  out  VPN_W-IDX_W  tag presented to the compare logic.
- hits_in  in  4  per-way hit vector, valid the cycle after arr_rd_en.
- valid_in  in  4  per-way valid bits of the indexed set, same timing as hits_in.
- ptw_req_valid  out  1  walk request.
- ptw_req_ready  in  1  PTW accepts the request.
- ptw_req_vpn  out  VPN_W  VPN to walk.
- ptw_resp_valid  in  1  walk done.
- ptw_resp_err  in  1  walk fault, qualified by ptw_resp_valid.
- refill_en  out  1  one-cycle write strobe.
- refill_way  out  4  one-hot victim way.
- flush  in  1  invalidate-all request pulse.
- flush_all  out  1  one-cycle invalidate-all strobe to the arrays.

Behaviour:
- Reset values: all outputs 0. FSM state = IDLE, repl_ptr = 0, last_grant = 1 (so ITLB wins the first tie), flush_pend = 0. Reset asserted in any state aborts the operation at once: any ptw_req is dropped, no response is produced.
- FSM states: IDLE, LOOKUP, COMPARE, PTW_REQ, PTW_WAIT, REFILL, RESP.
- IDLE, flush handling:
  - flush sets flush_pend in any state.
  - In IDLE with flush_pend=1: flush_all=1 for one cycle, flush_pend cleared, req_ready=0 that cycle.
  - A flush arriving in the same cycle it is serviced stays pending for the next IDLE cycle.
- IDLE, arbitration:
  - req_ready is combinational from req_valid and last_grant, only in IDLE with flush_pend=0.
  - If both requesters are valid, grant the one not equal to last_grant; a single valid requester is granted directly.
  - On a grant: latch owner and vpn, update last_grant, go to LOOKUP.
- LOOKUP: arr_rd_en=1 with arr_idx and arr_tag from the latched vpn; go to COMPARE. arr_idx and arr_tag hold the latched vpn in every non-IDLE state.
- COMPARE: sample hits_in and valid_in.
  - Any hit bit set (multi-hit treated as hit) -> RESP with fault=0.
  - Otherwise pick the victim: the lowest-numbered way with valid_in=0; if all are valid, way repl_ptr. Go to PTW_REQ.
- PTW_REQ: ptw_req_valid=1 and ptw_req_vpn=vpn, held until ptw_req_ready; then go to PTW_WAIT.
- PTW_WAIT: wait for ptw_resp_valid.
  - err=1 -> RESP with fault=1.
  - err=0 -> REFILL.
- REFILL: refill_en=1 for one cycle with refill_way=victim and arr_idx.
  - repl_ptr increments mod 4 only if the victim came from repl_ptr.
  - Go to LOOKUP (replay).
- RESP: resp_valid[owner]=1 and resp_fault set for one cycle; go to IDLE.
- Latency:
  - Hit: accept at cycle T, arr_rd_en at T+1, compare at T+2, resp_valid at T+3.
  - Miss, with PTW ready immediately and responding k cycles after acceptance: resp_valid at T+3+k+4.
- Requests are never dropped: a losing requester keeps req_valid and is granted on the next IDLE cycle. Only one transaction is outstanding at a time.

Test Plan:
- Hit path: reset, req_valid=01, vpn0=0x12345, hits_in=0100 at T+2 -> arr_idx=0x5 and arr_tag=0x1234 at T+1; resp_valid=01 and resp_fault=0 at T+3; no ptw_req.
- Arbitration tie: req_valid=11 held for consecutive transactions -> grants alternate 01, 10, 01; each req_ready is a one-cycle pulse, and only in IDLE.
- Miss with invalid way: hits_in=0000, valid_in=1011 -> ptw_req_vpn=vpn, held through 3 cycles of ptw_req_ready=0. After ptw_resp_valid with err=0: refill_en with refill_way=0100, then a replay arr_rd_en, then resp fault=0. repl_ptr stays 0.
- Full set replacement: valid_in=1111 on misses, repeated 5 times -> refill_way sequence 0001, 0010, 0100, 1000, 0001.
- PTW fault: ptw_resp_err=1 -> no refill_en; resp_valid[owner]=1 with resp_fault=1.
- Flush and reset: flush pulse during PTW_WAIT -> flush_all exactly once, on the first IDLE cycle after RESP, with req_ready=0 that cycle. Reset asserted in PTW_REQ -> next cycle all outputs 0; state IDLE and ptw_req_valid=0.
